// File: rtl/seg7_scan_mux.sv
// Time-multiplexed seven-segment scanner with blank interval and frame-synchronous update.
// Optional LEADING_ZERO_SUPPRESS_EN: dark leading zero digits (digit 0 always shown).
module seg7_scan_mux #(
  parameter int NUM_DIGITS     = 8,
  parameter int CLK_DIV        = 1000,
  parameter int BLANK_CYCLES   = 50,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   select,
  output logic [6:0]              segment7x,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_OFF =
    (SEL_ACTIVE_LOW != 0) ? '1 : '0;

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    pend_q, pend_d;
  logic [4*NUM_DIGITS-1:0] dig_pd_q, dig_pd_d;
  logic [NUM_DIGITS-1:0]   dp_pd_q, dp_pd_d;
  logic [NUM_DIGITS-1:0]   blk_pd_q, blk_pd_d;
  logic [4*NUM_DIGITS-1:0] dig_sh_q, dig_sh_d;
  logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
  logic [NUM_DIGITS-1:0]   blk_sh_q, blk_sh_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dpo_q, dpo_d;
  logic                    fd_q, fd_d;

  logic                    wrap;
  logic [NUM_DIGITS-1:0]   hide;
  logic [NUM_DIGITS-1:0]   sel_raw;
  logic [3:0]              nib;
  logic                    on;

  function automatic logic [6:0] dec7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
    return s;
  endfunction

  assign wrap = (idx_q == IDX_LAST) && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // A load on the wrap cycle bypasses the pending stage entirely.
  always_comb begin
    dig_pd_d = load ? digits : dig_pd_q;
    dp_pd_d  = load ? dp_in  : dp_pd_q;
    blk_pd_d = load ? blank  : blk_pd_q;
    pend_d   = wrap ? 1'b0 : (load | pend_q);
    dig_sh_d = dig_sh_q;
    dp_sh_d  = dp_sh_q;
    blk_sh_d = blk_sh_q;
    if (wrap && load) begin
      dig_sh_d = digits;
      dp_sh_d  = dp_in;
      blk_sh_d = blank;
    end else if (wrap && pend_q) begin
      dig_sh_d = dig_pd_q;
      dp_sh_d  = dp_pd_q;
      blk_sh_d = blk_pd_q;
    end
  end

`ifdef LEADING_ZERO_SUPPRESS_EN
  always_comb begin
    logic lead;
    lead = 1'b1;
    hide = blk_sh_d;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (lead && (dig_sh_d[i*4 +: 4] == 4'h0)) hide[i] = 1'b1;
      else lead = 1'b0;
    end
  end
`else
  assign hide = blk_sh_d;
`endif

  // Outputs are computed from next state so they line up with cnt/idx.
  always_comb begin
    nib     = dig_sh_d[idx_d*4 +: 4];
    on      = (cnt_d >= BLANK_END) && !hide[idx_d];
    sel_raw = '0;
    if (on) sel_raw[idx_d] = 1'b1;
    sel_d = (SEL_ACTIVE_LOW != 0) ? ~sel_raw : sel_raw;
    seg_d = on ? dec7(nib) : 7'h00;
    dpo_d = on & dp_sh_d[idx_d];
    fd_d  = (idx_d == IDX_LAST) && (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      pend_q   <= 1'b0;
      dig_pd_q <= '0;
      dp_pd_q  <= '0;
      blk_pd_q <= '0;
      dig_sh_q <= '0;
      dp_sh_q  <= '0;
      blk_sh_q <= '1;
      sel_q    <= SEL_OFF;
      seg_q    <= 7'h00;
      dpo_q    <= 1'b0;
      fd_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      dig_pd_q <= dig_pd_d;
      dp_pd_q  <= dp_pd_d;
      blk_pd_q <= blk_pd_d;
      dig_sh_q <= dig_sh_d;
      dp_sh_q  <= dp_sh_d;
      blk_sh_q <= blk_sh_d;
      sel_q    <= sel_d;
      seg_q    <= seg_d;
      dpo_q    <= dpo_d;
      fd_q     <= fd_d;
    end
  end

  assign select     = sel_q;
  assign segment7x  = seg_q;
  assign dp         = dpo_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux: 4 digits, 4 cycles/slot, 1 blank cycle.
// pos tracks the bench's own view of the frame position (slot*4 + k).
module tb_seg7_scan_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic [3:0]  blank;
  logic        load;
  logic [3:0]  select;
  logic [6:0]  segment7x;
  logic        dp;
  logic        frame_done;

  int n_tests = 0;
  int n_fail  = 0;
  int pos     = 0;

  seg7_scan_mux #(
    .NUM_DIGITS(4), .CLK_DIV(4), .BLANK_CYCLES(1), .SEL_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .digits(digits), .dp_in(dp_in),
    .blank(blank), .load(load), .select(select),
    .segment7x(segment7x), .dp(dp), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    pos = (pos + 1) % 16;
  endtask

  task automatic tick_to(input int p);
    while (pos != p) tick();
  endtask

  // Expected {select, segment7x, dp, frame_done} at frame position p.
  function automatic logic [12:0] expv(input int p, input logic [27:0] segs,
                                       input logic [3:0] dps,
                                       input logic [3:0] dark);
    int s, k;
    logic [3:0] sel;
    logic [6:0] sg;
    logic d;
    s = p / 4;
    k = p % 4;
    sel = 4'hF;
    sg = 7'h00;
    d = 1'b0;
    if (k >= 1 && !dark[s]) begin
      sel = ~(4'b0001 << s);
      sg = segs[s*7 +: 7];
      d = dps[s];
    end
    return {sel, sg, d, (p == 15)};
  endfunction

  task automatic test_reset();
    logic [12:0] e, g;
    rst = 1'b1; load = 1'b0;
    digits = '0; dp_in = '0; blank = '0;
    repeat (3) tick();
    n_tests++;
    g = {select, segment7x, dp, frame_done};
    if (g !== {4'hF, 7'h00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_hold got=%h exp=%h", g, {4'hF, 7'h00, 2'b00});
    end
    rst = 1'b0;
    pos = 0;
    for (int c = 0; c < 16; c++) begin
      e = expv(pos, '0, 4'h0, 4'hF);
      g = {select, segment7x, dp, frame_done};
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL first_frame pos=%0d got=%h exp=%h", pos, g, e);
      end
      tick();
    end
  endtask

  task automatic test_load_commit();
    logic [12:0] e, g;
    tick_to(5);
    digits = 16'h3A10; dp_in = 4'b0010; blank = 4'b0000; load = 1'b1;
    tick();
    load = 1'b0;
    while (pos != 0) begin
      e = expv(pos, '0, 4'h0, 4'hF);
      g = {select, segment7x, dp, frame_done};
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL load_no_tear pos=%0d got=%h exp=%h", pos, g, e);
      end
      tick();
    end
    for (int c = 0; c < 16; c++) begin
      e = expv(pos, {7'h4F, 7'h77, 7'h06, 7'h3F}, 4'b0010, 4'h0);
      g = {select, segment7x, dp, frame_done};
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL load_commit pos=%0d got=%h exp=%h", pos, g, e);
      end
      tick();
    end
  endtask

  task automatic test_free_run();
    int pulses = 0;
    for (int c = 0; c < 64; c++) begin
      if (frame_done === 1'b1) pulses++;
      n_tests++;
      if (frame_done !== (pos == 15)) begin
        n_fail++;
        $display("FAIL frame_done pos=%0d got=%b exp=%b",
                 pos, frame_done, (pos == 15));
      end
      tick();
    end
    n_tests++;
    if (pulses != 4) begin
      n_fail++;
      $display("FAIL frame_done_count got=%0d exp=4", pulses);
    end
  endtask

  task automatic test_wrap_load();
    logic [12:0] e, g;
    logic [3:0] dk;
`ifdef LEADING_ZERO_SUPPRESS_EN
    dk = 4'b1110;
`else
    dk = 4'b0000;
`endif
    tick_to(15);
    digits = 16'h0007; dp_in = 4'b0000; blank = 4'b0000; load = 1'b1;
    tick();
    load = 1'b0;
    for (int c = 0; c < 16; c++) begin
      e = expv(pos, {7'h3F, 7'h3F, 7'h3F, 7'h07}, 4'h0, dk);
      g = {select, segment7x, dp, frame_done};
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL wrap_load pos=%0d got=%h exp=%h", pos, g, e);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] e, g;
    logic [3:0] dk;
`ifdef LEADING_ZERO_SUPPRESS_EN
    dk = 4'b1110;
`else
    dk = 4'b0000;
`endif
    tick_to(2);
    digits = 16'h1111; load = 1'b1;
    tick();
    load = 1'b0;
    tick_to(9);
    digits = 16'h2222; load = 1'b1;
    tick();
    load = 1'b0;
    while (pos != 0) begin
      e = expv(pos, {7'h3F, 7'h3F, 7'h3F, 7'h07}, 4'h0, dk);
      g = {select, segment7x, dp, frame_done};
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL b2b_old_frame pos=%0d got=%h exp=%h", pos, g, e);
      end
      tick();
    end
    for (int c = 0; c < 16; c++) begin
      e = expv(pos, {7'h5B, 7'h5B, 7'h5B, 7'h5B}, 4'h0, 4'h0);
      g = {select, segment7x, dp, frame_done};
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL b2b_last_wins pos=%0d got=%h exp=%h", pos, g, e);
      end
      tick();
    end
  endtask

  task automatic test_mid_reset();
    logic [12:0] e, g;
    logic [3:0] dk;
`ifdef LEADING_ZERO_SUPPRESS_EN
    dk = 4'b1100;
`else
    dk = 4'b0000;
`endif
    tick_to(3);
    digits = 16'h0050; dp_in = 4'b0000; blank = 4'b0000; load = 1'b1;
    tick();
    load = 1'b0;
    tick_to(10);
    rst = 1'b1;
    tick();
    n_tests++;
    g = {select, segment7x, dp, frame_done};
    if (g !== {4'hF, 7'h00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset got=%h exp=%h", g, {4'hF, 7'h00, 2'b00});
    end
    rst = 1'b0;
    pos = 0;
    for (int c = 0; c < 32; c++) begin
      e = expv(pos, '0, 4'h0, 4'hF);
      g = {select, segment7x, dp, frame_done};
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL reset_dark pos=%0d got=%h exp=%h", pos, g, e);
      end
      tick();
    end
    load = 1'b1;
    tick();
    load = 1'b0;
    tick_to(0);
    for (int c = 0; c < 16; c++) begin
      e = expv(pos, {7'h3F, 7'h3F, 7'h6D, 7'h3F}, 4'h0, dk);
      g = {select, segment7x, dp, frame_done};
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL reload_0050 pos=%0d got=%h exp=%h", pos, g, e);
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load_commit();
    test_free_run();
    test_wrap_load();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
